// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - MIPS fetch stage: PC register, IF/ID pipeline register and decode field slicing
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic        misalign_err
);

    logic [31:0] pc;
    logic [31:0] pc_inc;

    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;

    // Redirect beats stall so a taken branch is never lost behind a hazard hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
            pc <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= 32'd0;
            pc_out   <= 32'd0;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (redirect || flush) begin
            instr    <= 32'd0;
            pc_out   <= 32'd0;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (!stall) begin
            instr    <= imem_data;
            pc_out   <= pc;
            pc_plus4 <= pc_inc;
            valid    <= 1'b1;
        end
    end

    // Sticky until reset; the misaligned target itself is still taken, force-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign jaddr  = instr[25:0];

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage with directed vectors
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr, pc_out, pc_plus4;
    logic        valid, misalign_err;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] jaddr;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] addr, ins, pc, pc4;
        logic        vld, mis;
        bit          dec;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] ja;
    } exp_t;

    exp_t q[$];

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4), .valid(valid),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .jaddr(jaddr), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0010: memf = 32'h2008_FFFA;
            32'h0000_0014: memf = 32'h0109_5020;
            32'h0000_0100: memf = 32'h8C22_0004;
            default:       memf = 32'h2008_000A;
        endcase
    endfunction

    always_comb imem_data = memf(imem_addr);

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @cyc%0d: got %h, expected %h", n, cyc, act, req);
        end
    endtask

    // Expectation for the state visible after the next rising edge.
    task automatic ex(input string n, input logic [31:0] addr, input logic vld,
                      input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic mis);
        exp_t e;
        e = '{cyc: cyc + 1, name: n, addr: addr, ins: ins, pc: pc, pc4: pc4,
              vld: vld, mis: mis, dec: 1'b0, op: '0, fn: '0, rs: '0, rt: '0,
              rd: '0, sh: '0, imm: '0, ja: '0};
        q.push_back(e);
    endtask

    task automatic exd(input logic [5:0] op, input logic [4:0] r_s, input logic [4:0] r_t,
                       input logic [4:0] r_d, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] imm, input logic [25:0] ja);
        q[$].dec = 1'b1;
        q[$].op = op; q[$].rs = r_s; q[$].rt = r_t; q[$].rd = r_d;
        q[$].sh = sh; q[$].fn = fn; q[$].imm = imm; q[$].ja = ja;
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic rd_i, input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd_i; redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                check({e.name, ".missed"}, cyc, e.cyc);
            end else begin
                check({e.name, ".imem_addr"}, imem_addr, e.addr);
                check({e.name, ".valid"}, {31'd0, valid}, {31'd0, e.vld});
                check({e.name, ".instr"}, instr, e.ins);
                check({e.name, ".pc_out"}, pc_out, e.pc);
                check({e.name, ".pc_plus4"}, pc_plus4, e.pc4);
                check({e.name, ".misalign"}, {31'd0, misalign_err}, {31'd0, e.mis});
                if (e.dec) begin
                    check({e.name, ".opcode"}, {26'd0, opcode}, {26'd0, e.op});
                    check({e.name, ".rs"}, {27'd0, rs}, {27'd0, e.rs});
                    check({e.name, ".rt"}, {27'd0, rt}, {27'd0, e.rt});
                    check({e.name, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
                    check({e.name, ".shamt"}, {27'd0, shamt}, {27'd0, e.sh});
                    check({e.name, ".funct"}, {26'd0, funct}, {26'd0, e.fn});
                    check({e.name, ".imm16"}, {16'd0, imm16}, {16'd0, e.imm});
                    check({e.name, ".jaddr"}, {6'd0, jaddr}, {6'd0, e.ja});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got cycle %0d, expected < 10000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        drive(1, 0, 0, 0, 0);
        step();
        ex("reset", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
        exd(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0);
        step();

        drive(0, 0, 0, 0, 0);
        ex("run0", 32'h4, 1, 32'h2008_000A, 32'h0, 32'h4, 0);
        exd(6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0A, 16'h000A, 26'h008_000A);
        step();
        ex("run4", 32'h8, 1, 32'h2008_000A, 32'h4, 32'h8, 0);
        step();
        ex("run8", 32'hC, 1, 32'h2008_000A, 32'h8, 32'hC, 0);
        step();
        ex("runC", 32'h10, 1, 32'h2008_000A, 32'hC, 32'h10, 0);
        step();
        ex("negimm", 32'h14, 1, 32'h2008_FFFA, 32'h10, 32'h14, 0);
        exd(6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3A, 16'hFFFA, 26'h008_FFFA);
        step();
        ex("rtype", 32'h18, 1, 32'h0109_5020, 32'h14, 32'h18, 0);
        exd(6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h5020, 26'h109_5020);
        step();
        ex("run18", 32'h1C, 1, 32'h2008_000A, 32'h18, 32'h1C, 0);
        step();
        ex("run1C", 32'h20, 1, 32'h2008_000A, 32'h1C, 32'h20, 0);
        step();

        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            ex("stall", 32'h20, 1, 32'h2008_000A, 32'h1C, 32'h20, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        ex("unstall", 32'h24, 1, 32'h2008_000A, 32'h20, 32'h24, 0);
        step();

        drive(0, 1, 1, 1, 32'h0000_0100);
        ex("redir_all", 32'h100, 0, 32'h0, 32'h0, 32'h0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        ex("redir_tgt", 32'h104, 1, 32'h8C22_0004, 32'h100, 32'h104, 0);
        step();

        drive(0, 0, 1, 0, 0);
        ex("flush", 32'h108, 0, 32'h0, 32'h0, 32'h0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        ex("post_flush", 32'h10C, 1, 32'h2008_000A, 32'h108, 32'h10C, 0);
        step();

        drive(0, 0, 0, 1, 32'h0000_0203);
        ex("misalign", 32'h200, 0, 32'h0, 32'h0, 32'h0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        ex("mis_tgt", 32'h204, 1, 32'h2008_000A, 32'h200, 32'h204, 1);
        step();
        for (int i = 0; i < 8; i++) step();
        ex("mis_sticky", 32'h228, 1, 32'h2008_000A, 32'h224, 32'h228, 1);
        step();

        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        ex("redir_top", 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 32'h0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        ex("wrap", 32'h0, 1, 32'h2008_000A, 32'hFFFF_FFFC, 32'h0, 1);
        step();
        ex("wrap1", 32'h4, 1, 32'h2008_000A, 32'h0, 32'h4, 1);
        step();
        ex("wrap2", 32'h8, 1, 32'h2008_000A, 32'h4, 32'h8, 1);
        step();

        drive(1, 1, 0, 0, 0);
        ex("rst_mid", 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
        exd(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0);
        step();
        drive(0, 0, 0, 0, 0);
        ex("post_rst", 32'h4, 1, 32'h2008_000A, 32'h0, 32'h4, 0);
        step();

        drive(0, 1, 1, 0, 0);
        ex("flush_stall", 32'h4, 0, 32'h0, 32'h0, 32'h0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        ex("post_fs", 32'h8, 1, 32'h2008_000A, 32'h4, 32'h8, 0);
        step();

        step();
        step();
        check("scoreboard_leftover", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch and IF/ID pipeline register of the MIPS datapath, directly upstream of SignExtend. It owns the program counter, drives the instruction-memory address, and latches the fetched word with its PC. It splits the word into decode fields; imm16 feeds SignExtend.Imm16 and the other fields feed the control unit and register file. It supports stall, flush and branch/jump redirect from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC and IF/ID contents (hazard unit)
flush  in  1  replace IF/ID contents with a bubble
redirect  in  1  branch/jump taken; load redirect_pc into PC
redirect_pc  in  32  redirect target
imem_addr  out  32  current PC to instruction memory (= PC register)
imem_data  in  32  instruction word, combinational read of imem_addr
instr  out  32  latched instruction in ID
pc_out  out  32  PC of instruction in ID
pc_plus4  out  32  pc_out + 4
valid  out  1  ID holds a real instruction (0 = bubble)
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
imm16  out  16  instr[15:0], to SignExtend
jaddr  out  26  instr[25:0]
misalign_err  out  1  sticky: a redirect target had nonzero bits [1:0]

Behaviour:
- Reset (rst=1 at edge): PC=RESET_PC; instr=0, pc_out=0, pc_plus4=0, valid=0, misalign_err=0. All decode fields are therefore 0. rst overrides all other inputs, including mid-stall and mid-redirect.
- PC next-state priority: rst > redirect > stall > increment.
  - redirect: PC = {redirect_pc[31:2], 2'b00}.
  - stall: PC holds.
  - otherwise: PC = PC + 4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- IF/ID next-state priority: rst > (redirect | flush) > stall > load.
  - redirect or flush: bubble. instr=0 (sll $0,$0,0), pc_out=0, pc_plus4=0, valid=0.
  - stall: instr, pc_out, pc_plus4 and valid hold their values.
  - load: instr=imem_data, pc_out=PC, pc_plus4=PC+4, valid=1.
- Simultaneous events:
  - redirect+stall: PC takes the target and IF/ID is bubbled; redirect wins.
  - flush+stall without redirect: IF/ID is bubbled and PC holds.
  - flush alone: IF/ID is bubbled and PC increments.
- misalign_err: set on any edge with redirect=1 and redirect_pc[1:0]!=0. It stays set until rst. The target is still taken, force-aligned.
- Latency:
  - imem_addr equals the PC register; no combinational path from inputs to imem_addr.
  - The word fetched at address A in cycle n appears on instr/pc_out in cycle n+1.
  - Decode fields are purely combinational slices of the instr register (0 extra cycles). imm16 is valid for SignExtend in the same cycle as instr.
- No X on any output after the first reset edge.

Test Plan:
- Reset then free run: rst high 2 cycles, RESET_PC=0, imem returns 0x2008_000A. Then pc_out=0, valid=1, opcode=0x08, rs=0, rt=8, imm16=0x000A, pc_plus4=4, and imem_addr steps 4, 8, 0xC on successive cycles.
- Negative immediate: imem_data=0x2008_FFFA at PC=0x10. Next cycle imm16=0xFFFA, rt=8, pc_out=0x10, pc_plus4=0x14. R-type 0x0109_5020 → rs=8, rt=9, rd=10, shamt=0, funct=0x20.
- Stall: stall=1 for 3 cycles at PC=0x20. imem_addr stays 0x20, and instr/pc_out/valid are unchanged for 3 cycles. On release, PC advances to 0x24.
- Redirect with stall and flush: redirect=1, redirect_pc=0x0000_0100, stall=1, flush=1 in the same cycle. Next cycle imem_addr=0x100, valid=0, instr=0. The following cycle pc_out=0x100, valid=1.
- Misaligned redirect and wrap:
  - redirect_pc=0x0000_0203 → imem_addr=0x200 and misalign_err=1, remaining 1 after 10 more cycles.
  - redirect to 0xFFFF_FFFC → next imem_addr=0x0000_0000.
  - rst clears misalign_err.
- Reset mid-operation: assert rst while valid=1 and stall=1. Next cycle PC=RESET_PC, valid=0, instr=0, misalign_err=0.
